// File: rtl/pcie_pkt_parser_if.sv
// ------------------------------------------------------------------
// pcie_pkt_parser_if - inbound word, header and payload bundle. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface pcie_pkt_parser_if;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] hdr_cmd;
  logic [31:0] hdr_addr;
  logic [31:0] hdr_len;
  logic [31:0] hdr_param;
  logic        hdr_valid;
  logic        hdr_ready;
  logic [31:0] pay_data;
  logic        pay_valid;
  logic        pay_ready;
  logic        pay_last;
  logic        err_opcode;
  logic        err_len;
  logic [15:0] pkt_count;

  modport slave (
    input  in_data, in_valid, hdr_ready, pay_ready,
    output in_ready, hdr_cmd, hdr_addr, hdr_len, hdr_param, hdr_valid,
           pay_data, pay_valid, pay_last, err_opcode, err_len, pkt_count
  );

  modport master (
    output in_data, in_valid, hdr_ready, pay_ready,
    input  in_ready, hdr_cmd, hdr_addr, hdr_len, hdr_param, hdr_valid,
           pay_data, pay_valid, pay_last, err_opcode, err_len, pkt_count
  );
endinterface

`default_nettype wire

// File: rtl/pcie_pkt_parser.sv
// ------------------------------------------------------------------
// pcie_pkt_parser - splits 4-word headers from pass-through payload. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module pcie_pkt_parser #(
  parameter int MAX_LEN = 512
) (
  input  wire logic          pcie_clk,
  input  wire logic          pcie_rst_n,
  pcie_pkt_parser_if.slave   bus
);

  typedef enum logic [1:0] {
    S_HDR     = 2'd0,
    S_HOLD    = 2'd1,
    S_PAYLOAD = 2'd2
  } state_t;

  localparam logic [31:0] c_MAX_LEN = 32'(MAX_LEN);

  state_t      r_state;
  logic [1:0]  r_wcnt;
  logic [31:0] r_cmd;
  logic [31:0] r_addr;
  logic [31:0] r_len;
  logic [31:0] r_param;
  logic [31:0] r_remaining;
  logic        r_hdr_valid;
  logic        r_err_opcode;
  logic        r_err_len;
  logic [15:0] r_pkt_count;

  logic [7:0]  w_op;
  logic        w_op_ok;
  logic        w_has_pay;
  logic        w_len_bad;
  logic        w_in_payload;

  // Opcode and length come from words 0 and 2, already latched when word 3 lands.
  assign w_op         = r_cmd[31:24];
  assign w_op_ok      = (w_op >= 8'h01) && (w_op <= 8'h06);
  assign w_has_pay    = (w_op == 8'h01) || (w_op == 8'h02);
  assign w_len_bad    = w_has_pay && (r_len > c_MAX_LEN);
  assign w_in_payload = (r_state == S_PAYLOAD);

  assign bus.in_ready   = (r_state == S_HDR) || (w_in_payload && bus.pay_ready);
  assign bus.pay_valid  = w_in_payload && bus.in_valid;
  assign bus.pay_data   = w_in_payload ? bus.in_data : 32'd0;
  assign bus.pay_last   = w_in_payload && (r_remaining == 32'd1);
  assign bus.hdr_cmd    = r_cmd;
  assign bus.hdr_addr   = r_addr;
  assign bus.hdr_len    = r_len;
  assign bus.hdr_param  = r_param;
  assign bus.hdr_valid  = r_hdr_valid;
  assign bus.err_opcode = r_err_opcode;
  assign bus.err_len    = r_err_len;
  assign bus.pkt_count  = r_pkt_count;

  always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
    if (!pcie_rst_n) begin
      r_state      <= S_HDR;
      r_wcnt       <= 2'd0;
      r_cmd        <= 32'd0;
      r_addr       <= 32'd0;
      r_len        <= 32'd0;
      r_param      <= 32'd0;
      r_remaining  <= 32'd0;
      r_hdr_valid  <= 1'b0;
      r_err_opcode <= 1'b0;
      r_err_len    <= 1'b0;
      r_pkt_count  <= 16'd0;
    end else begin
      r_err_opcode <= 1'b0;
      r_err_len    <= 1'b0;
      case (r_state)
        S_HDR: begin
          if (bus.in_valid) begin
            case (r_wcnt)
              2'd0: r_cmd   <= bus.in_data;
              2'd1: r_addr  <= bus.in_data;
              2'd2: r_len   <= bus.in_data;
              2'd3: r_param <= bus.in_data;
              default: r_cmd <= bus.in_data;
            endcase
            // Counter wraps 3->0 so a rejected header restarts at word 0.
            r_wcnt <= r_wcnt + 2'd1;
            if (r_wcnt == 2'd3) begin
              if (!w_op_ok) begin
                r_err_opcode <= 1'b1;
              end else if (w_len_bad) begin
                r_err_len <= 1'b1;
              end else begin
                r_state     <= S_HOLD;
                r_hdr_valid <= 1'b1;
              end
            end
          end
        end
        S_HOLD: begin
          if (bus.hdr_ready) begin
            r_hdr_valid <= 1'b0;
            r_pkt_count <= r_pkt_count + 16'd1;
            if (w_has_pay && (r_len != 32'd0)) begin
              r_state     <= S_PAYLOAD;
              r_remaining <= r_len;
            end else begin
              r_state <= S_HDR;
            end
          end
        end
        S_PAYLOAD: begin
          if (bus.in_valid && bus.pay_ready) begin
            r_remaining <= r_remaining - 32'd1;
            if (r_remaining == 32'd1) begin
              r_state <= S_HDR;
            end
          end
        end
        default: r_state <= S_HDR;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/pcie_pkt_parser.md
PCIE_PKT_PARSER -- requirements
Module: pcie_pkt_parser

Interface
REQ-001 SHALL have parameter: MAX_LEN, 512, maximum payload words accepted for opcodes 0x01/0x02.
REQ-002 SHALL have port: pcie_clk  input  1  single clock; all logic is on the rising edge.
REQ-003 SHALL have port: pcie_rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port: in_data  input  32  raw inbound PCIe word stream.
REQ-005 SHALL have port: in_valid  input  1  in_data valid.
REQ-006 SHALL have port: in_ready  output  1  parser accepts in_data; a word transfers when in_valid & in_ready.
REQ-007 SHALL have ports: hdr_cmd, hdr_addr, hdr_len, hdr_param  output  32 each  registered header words 0..3.
REQ-008 SHALL have ports: hdr_valid  output  1; hdr_ready  input  1  header handshake to the controller.
REQ-009 SHALL have ports: pay_data  output  32; pay_valid  output  1; pay_ready  input  1; pay_last  output  1  payload stream.
REQ-010 SHALL have ports: err_opcode, err_len  output  1 each  one-cycle error pulses.
REQ-011 SHALL have port: pkt_count  output  16  count of headers delivered.

Function
REQ-012 SHALL implement states HDR, HOLD, PAYLOAD; reset state is HDR.
REQ-013 In HDR: in_ready=1; each accepted word SHALL be stored in the header slot given by a 2-bit word counter (0=cmd, 1=addr, 2=len, 3=param).
REQ-014 On acceptance of word 3, the opcode SHALL be taken from cmd[31:24]; valid opcodes are 0x01-0x06.
REQ-015 Invalid opcode: no header is emitted; err_opcode SHALL pulse for exactly one cycle, on the cycle after word 3 is accepted; state stays HDR; word counter returns to 0.
REQ-016 Opcode 0x01/0x02 with len > MAX_LEN: no header is emitted; err_len SHALL pulse for one cycle with the same timing as REQ-015; state stays HDR; no words are dropped.
REQ-017 Otherwise SHALL go to HOLD: hdr_valid=1 on the cycle after word 3 is accepted; all hdr_* held stable; in_ready=0.
REQ-018 HOLD exit on hdr_valid & hdr_ready: to PAYLOAD if the opcode is 0x01/0x02 and len>0; otherwise to HDR. hdr_valid SHALL be 0 on the following cycle.
REQ-019 A 32-bit remaining counter SHALL load hdr_len on the HOLD->PAYLOAD transition.
REQ-020 PAYLOAD SHALL be zero-latency pass-through: pay_data=in_data, pay_valid=in_valid, in_ready=pay_ready.
REQ-021 pay_last SHALL be 1 in PAYLOAD when remaining==1.
REQ-022 Each in_valid & pay_ready in PAYLOAD SHALL decrement remaining; the transfer with pay_last=1 SHALL return the state to HDR on the next cycle.
REQ-023 Outside PAYLOAD, pay_valid and pay_last SHALL be 0; in_data is never forwarded as payload.
REQ-024 pkt_count SHALL increment on each hdr_valid & hdr_ready and wrap 0xFFFF->0x0000; errored headers are not counted.
REQ-025 Stall in any state (in_valid=0, hdr_ready=0 or pay_ready=0) SHALL hold all state, counters and registered outputs unchanged.
REQ-026 Opcodes 0x03-0x06 SHALL carry no payload regardless of len; the next inbound word is the next header's word 0.

Reset
REQ-027 While pcie_rst_n=0: state=HDR, word counter=0, remaining=0, hdr_* =0, hdr_valid=0, err_*=0, pkt_count=0, pay_valid=0, pay_last=0; in_ready=1 once reset is released.
REQ-028 Reset asserted mid-header or mid-payload SHALL abandon the packet; after release, the first accepted word is treated as header word 0.

Verification
REQ-029 Words {0x01000000, 0x1000, 3, 0}, then A,B,C with hdr_ready=1 and pay_ready=1 -> one header with hdr_len=3; payload A,B,C with pay_last only on C; pkt_count=1.
REQ-030 Header {0x03xxxxxx, 0, 100, 7} followed by another header -> hdr_valid once, no payload, the second header parses normally.
REQ-031 cmd=0x09000000 -> err_opcode one-cycle pulse, no hdr_valid; the next 4 words parse as a fresh header.
REQ-032 cmd=0x02000000, len=513 (MAX_LEN=512) -> err_len pulse, no header, pkt_count unchanged.
REQ-033 hdr_ready held 0 for 10 cycles, then pay_ready toggling every cycle -> in_ready=0 throughout HOLD; payload order is intact; len=0 with opcode 0x01 -> HOLD->HDR.
REQ-034 pcie_rst_n pulsed low after 2 payload words of 5, then a new header -> all outputs at reset values; the new header is parsed correctly.
